// File: rtl/delay_and_sum_udiv_20ns_13ns_8_seq_if.sv
// Operand/result handshake bundle for the sequential 20/13 -> 8-bit unsigned divider.
interface delay_and_sum_udiv_20ns_13ns_8_seq_if #(
  parameter int DIVIDEND_W = 20,
  parameter int DIVISOR_W  = 13,
  parameter int QUOT_W     = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  out_valid;
  logic                  out_ready;
  logic [QUOT_W-1:0]     quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;
  logic                  overflow;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/delay_and_sum_udiv_20ns_13ns_8_seq.sv
// Restoring unsigned divider, one quotient bit per cycle; recovers the 8-bit factor of a
// 20-bit scaled product and flags divide-by-zero / quotient overflow.
module delay_and_sum_udiv_20ns_13ns_8_seq #(
  parameter int DIVIDEND_W = 20,
  parameter int DIVISOR_W  = 13,
  parameter int QUOT_W     = 8
) (
  input logic ap_clk,
  input logic ap_rst,
  delay_and_sum_udiv_20ns_13ns_8_seq_if.slave bus
);
  localparam int CNT_W = $clog2(QUOT_W + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t                state, state_nxt;
  logic [DIVISOR_W-1:0]  rem_r, dvs_r, remainder_r;
  logic [QUOT_W-1:0]     shf_r, quotient_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  dz_r, ov_r;
  logic [DIVIDEND_W-1:0] hi, dvs_ext;
  logic                  zero_case, ovf_case, bypass, last_step;
  logic [DIVISOR_W:0]    step_out;
  logic [QUOT_W-1:0]     quot_next;

  // One restoring step: returns {quotient bit, new partial remainder}.
  function automatic logic [DIVISOR_W:0] div_step(input logic [DIVISOR_W-1:0] r,
                                                  input logic                 b,
                                                  input logic [DIVISOR_W-1:0] d);
    logic [DIVISOR_W:0] t, diff;
    t    = {r, b};
    diff = t - {1'b0, d};
    if (t >= {1'b0, d}) div_step = {1'b1, diff[DIVISOR_W-1:0]};
    else                div_step = {1'b0, t[DIVISOR_W-1:0]};
  endfunction

  assign hi        = bus.dividend >> QUOT_W;
  assign dvs_ext   = DIVIDEND_W'(bus.divisor);
  assign zero_case = (bus.divisor == '0);
  assign ovf_case  = (hi >= dvs_ext);
  // Flagged operands still spend one CALC cycle so their timing matches the result slot.
  assign bypass    = dz_r | ov_r;
  assign last_step = bypass || (cnt_r == CNT_W'(QUOT_W - 1));
  assign step_out  = div_step(rem_r, shf_r[QUOT_W-1], dvs_r);
  assign quot_next = {shf_r[QUOT_W-2:0], step_out[DIVISOR_W]};

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = CALC;
      CALC:    if (last_step) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      rem_r       <= '0;
      dvs_r       <= '0;
      shf_r       <= '0;
      cnt_r       <= '0;
      dz_r        <= 1'b0;
      ov_r        <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
    end else begin
      case (state)
        // accept: low dividend bits become the shift register that collects quotient bits
        IDLE: if (bus.in_valid) begin
          rem_r <= hi[DIVISOR_W-1:0];
          shf_r <= bus.dividend[QUOT_W-1:0];
          dvs_r <= bus.divisor;
          cnt_r <= '0;
          dz_r  <= zero_case;
          ov_r  <= ~zero_case & ovf_case;
        end
        // iterate: MSB-first restoring steps, results published only on the final step
        CALC: begin
          rem_r <= step_out[DIVISOR_W-1:0];
          shf_r <= quot_next;
          cnt_r <= cnt_r + CNT_W'(1);
          if (last_step) begin
            quotient_r  <= bypass ? '1 : quot_next;
            remainder_r <= bypass ? '0 : step_out[DIVISOR_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dz_r;
  assign bus.overflow    = ov_r;
endmodule

// File: tb/tb_delay_and_sum_udiv_20ns_13ns_8_seq.sv
// Bench for the sequential divider: directed cases plus randomized traffic against a division model.
module tb_delay_and_sum_udiv_20ns_13ns_8_seq;
  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  always #5 ap_clk = ~ap_clk;

  delay_and_sum_udiv_20ns_13ns_8_seq_if bus ();
  delay_and_sum_udiv_20ns_13ns_8_seq dut (.ap_clk(ap_clk), .ap_rst(ap_rst), .bus(bus));

  typedef struct {
    int unsigned a, d, q, r;
    bit dz, ov;
    int lat, acc;
    bit seen;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge ap_clk) cyc++;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int unsigned a, input int unsigned d);
    exp_t e;
    e.a = a; e.d = d; e.dz = 0; e.ov = 0; e.seen = 0; e.acc = 0;
    if (d == 0) begin
      e.q = 255; e.r = 0; e.dz = 1; e.lat = 1;
    end else if (a / d > 255) begin
      e.q = 255; e.r = 0; e.ov = 1; e.lat = 1;
    end else begin
      e.q = a / d; e.r = a % d; e.lat = 8;
    end
    return e;
  endfunction

  // Scoreboard: every cycle a result is presented it must match the oldest accepted operation.
  always @(negedge ap_clk) begin
    exp_t e;
    if (ap_rst) begin
      sb.delete();
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_quotient", bus.quotient, 0);
      chk("rst_remainder", bus.remainder, 0);
    end else begin
      if (bus.out_valid) begin
        if (sb.size() == 0) chk("spurious_out_valid", 1, 0);
        else begin
          e = sb[0];
          chk("sb_quotient", bus.quotient, e.q);
          chk("sb_remainder", bus.remainder, e.r);
          chk("sb_div_by_zero", bus.div_by_zero, e.dz);
          chk("sb_overflow", bus.overflow, e.ov);
          chk("sb_in_ready_low", bus.in_ready, 0);
          if (!e.seen) begin
            sb[0].seen = 1;
            chk("sb_latency", cyc - e.acc, e.lat);
            if (!e.dz && !e.ov) begin
              chk("sb_invariant", longint'(bus.quotient) * e.d + bus.remainder, e.a);
              chk("sb_rem_lt_div", (bus.remainder < e.d), 1);
            end
          end
          if (bus.out_ready) void'(sb.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e = model(bus.dividend, bus.divisor);
        e.acc = cyc + 1;
        sb.push_back(e);
      end
    end
  end

  // Called aligned just after a rising edge; returns the accept edge index.
  task automatic issue(input int unsigned a, input int unsigned d, output int k);
    bus.in_valid = 1'b1;
    bus.dividend = 20'(a);
    bus.divisor  = 13'(d);
    for (int n = 0; n < 30; n++) begin
      @(negedge ap_clk);
      if (bus.in_ready) break;
    end
    if (!bus.in_ready) chk("accept_timeout", 0, 1);
    @(posedge ap_clk); #1;
    bus.in_valid = 1'b0;
    k = cyc;
  endtask

  task automatic run_dir(input string name, input int unsigned a, input int unsigned d,
                         input int eq, input int er, input bit edz, input bit eov,
                         input int elat, input int hold, input bit inject);
    int k;
    int n;
    bus.out_ready = (hold == 0);
    issue(a, d, k);
    n = 0;
    while (n < 20) begin
      @(negedge ap_clk);
      n++;
      if (bus.out_valid) break;
    end
    chk({name, "_out_valid"}, bus.out_valid, 1);
    chk({name, "_latency"}, cyc - k, elat);
    chk({name, "_quotient"}, bus.quotient, eq);
    chk({name, "_remainder"}, bus.remainder, er);
    chk({name, "_div_by_zero"}, bus.div_by_zero, edz);
    chk({name, "_overflow"}, bus.overflow, eov);
    for (int i = 0; i < hold; i++) begin
      @(posedge ap_clk); #1;
      if (inject && i == 1) begin
        bus.in_valid = 1'b1; bus.dividend = 20'd9; bus.divisor = 13'd3;
      end else bus.in_valid = 1'b0;
      @(negedge ap_clk);
      chk({name, "_hold_in_ready"}, bus.in_ready, 0);
      chk({name, "_hold_quotient"}, bus.quotient, eq);
    end
    if (hold != 0) begin
      @(posedge ap_clk); #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    @(posedge ap_clk);
    @(negedge ap_clk);
    chk({name, "_in_ready_after"}, bus.in_ready, 1);
    @(posedge ap_clk); #1;
  endtask

  initial begin
    exp_t e;
    int k;
    int ops;
    int guard;
    bit acc;
    int unsigned d, q, r, qmax;

    bus.in_valid = 1'b0; bus.dividend = '0; bus.divisor = '0; bus.out_ready = 1'b0;

    e = model(1000, 7);
    chk("model_1000_7_q", e.q, 142);
    chk("model_1000_7_r", e.r, 6);
    e = model(5000, 19);
    chk("model_5000_19_ov", e.ov, 1);

    repeat (2) @(posedge ap_clk);
    #1;
    chk("reset_div_by_zero", bus.div_by_zero, 0);
    chk("reset_overflow", bus.overflow, 0);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    chk("reset_in_ready", bus.in_ready, 1);
    @(posedge ap_clk); #1;

    run_dir("d1000_7", 1000, 7, 142, 6, 0, 0, 8, 0, 0);
    run_dir("d3327_13", 3327, 13, 255, 12, 0, 0, 8, 0, 0);
    run_dir("dmax", 1048575, 8191, 128, 127, 0, 0, 8, 0, 0);
    run_dir("dovf", 5000, 19, 255, 0, 0, 1, 1, 0, 0);
    run_dir("dzero", 123, 0, 255, 0, 1, 0, 1, 0, 0);
    run_dir("dhold", 1000, 7, 142, 6, 0, 0, 8, 5, 1);
    run_dir("d9_3", 9, 3, 3, 0, 0, 0, 8, 0, 0);

    // Abort in the middle of a calculation.
    bus.out_ready = 1'b1;
    issue(1000, 7, k);
    repeat (3) @(posedge ap_clk);
    #1 ap_rst = 1'b1;
    @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    @(negedge ap_clk);
    chk("abort_in_ready", bus.in_ready, 1);
    chk("abort_quotient", bus.quotient, 0);
    chk("abort_remainder", bus.remainder, 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge ap_clk);
      chk("abort_no_out_valid", bus.out_valid, 0);
    end
    @(posedge ap_clk); #1;
    run_dir("d255_1", 255, 1, 255, 0, 0, 0, 8, 0, 0);

    // Random legal operands with random result back-pressure.
    ops = 0;
    guard = 0;
    while (ops < 2000 && guard < 80000) begin
      @(negedge ap_clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge ap_clk); #1;
      guard++;
      if (acc) begin
        ops++;
        bus.in_valid = 1'b0;
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      if (!bus.in_valid && ops < 2000) begin
        d = $urandom_range(1, 8191);
        qmax = (1048575 - (d - 1)) / d;
        if (qmax > 255) qmax = 255;
        q = $urandom_range(0, qmax);
        r = $urandom_range(0, d - 1);
        bus.dividend = 20'(q * d + r);
        bus.divisor  = 13'(d);
        bus.in_valid = 1'b1;
      end
    end
    chk("random_ops_completed", ops, 2000);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge ap_clk);
    chk("drain_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
